// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory read port plus the decode-side
// instruction/handshake signals. The controller uses the master modport.
interface imem_fetch_ctrl_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    output instr,
    output instr_valid,
    output pc_out,
    input  stall,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    input  instr,
    input  instr_valid,
    input  pc_out,
    output stall,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory read per
// instruction, waits MEM_LAT cycles, and holds the word for decode until it
// is consumed. Redirects restart fetch at a new target; a misaligned target
// or running off the end of memory parks the controller in HALT.
module imem_fetch_ctrl #(
  parameter int          MEM_SIZE = 128,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          MEM_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  imem_fetch_ctrl_if.master  bus,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);
  localparam logic [2:0]  LAT_INIT   = 3'(MEM_LAT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_reg,   state_next;
  logic [31:0] pc_reg,      pc_next;
  logic [31:0] instr_reg,   instr_next;
  logic [31:0] pc_out_reg,  pc_out_next;
  logic        valid_reg,   valid_next;
  logic        fault_reg,   fault_next;
  logic [31:0] count_reg,   count_next;
  logic [2:0]  lat_cnt_reg, lat_cnt_next;

  // Outputs come only from registers and state, never from inputs.
  assign bus.mem_addr    = pc_reg;
  assign bus.mem_rd      = (state_reg == ISSUE) && (pc_reg < ADDR_LIMIT);
  assign bus.instr       = instr_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.pc_out      = pc_out_reg;
  assign halted          = (state_reg == HALT);
  assign fault           = fault_reg;
  assign fetch_count     = count_reg;

  // State and datapath registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= 32'h0;
      pc_out_reg  <= 32'h0;
      valid_reg   <= 1'b0;
      fault_reg   <= 1'b0;
      count_reg   <= 32'h0;
      lat_cnt_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      pc_out_reg  <= pc_out_next;
      valid_reg   <= valid_next;
      fault_reg   <= fault_next;
      count_reg   <= count_next;
      lat_cnt_reg <= lat_cnt_next;
    end
  end

  // Next-state and datapath update; redirect outranks every other event
  // while a fetch is active, including a stall or a data capture.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    pc_out_next  = pc_out_reg;
    valid_next   = valid_reg;
    fault_next   = fault_reg;
    count_next   = count_reg;
    lat_cnt_next = lat_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          pc_next    = RESET_PC;
          count_next = 32'h0;
        end
      end

      ISSUE, WAIT, HOLD: begin
        if (bus.redirect) begin
          valid_next = 1'b0;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            // Misaligned target: keep the PC, flag it and stop.
            fault_next = 1'b1;
            state_next = HALT;
          end else begin
            pc_next      = bus.redirect_pc;
            lat_cnt_next = 3'd0;
            state_next   = ISSUE;
          end
        end else begin
          case (state_reg)
            ISSUE: begin
              if (pc_reg >= ADDR_LIMIT) begin
                state_next = HALT;
              end else begin
                lat_cnt_next = LAT_INIT;
                state_next   = WAIT;
              end
            end
            WAIT: begin
              lat_cnt_next = lat_cnt_reg - 3'd1;
              if (lat_cnt_reg == 3'd1) begin
                instr_next  = bus.mem_rdata;
                pc_out_next = pc_reg;
                valid_next  = 1'b1;
                pc_next     = pc_reg + 32'd4;
                state_next  = HOLD;
              end
            end
            default: begin
              // HOLD: an unstalled edge hands the word to decode.
              if (!bus.stall) begin
                count_next = count_reg + 32'd1;
                valid_next = 1'b0;
                state_next = ISSUE;
              end
            end
          endcase
        end
      end

      HALT: begin
        valid_next = 1'b0;
        if (start) begin
          state_next = ISSUE;
          pc_next    = RESET_PC;
          count_next = 32'h0;
          fault_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction memory's word-aligned byte address. It issues one read per instruction, waits a fixed memory latency, and holds the fetched word for the decode stage under a valid/stall handshake. It also accepts branch/jump redirects and halts cleanly at the end of memory or on a misaligned target. It sits between the instruction memory and the decode/control unit of the processor.

## Interface

- MEM_SIZE, 128, instruction memory depth in 32-bit words; the byte address limit is MEM_SIZE*4.
- RESET_PC, 32'h0, start address (byte, word-aligned).
- MEM_LAT, 1, memory read latency in cycles; legal range is 1..4.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from RESET_PC; honoured in IDLE and HALT only.
- stall  in  1  decode is not ready; hold the current instruction.
- redirect  in  1  load a new PC (branch/jump taken).
- redirect_pc  in  32  byte target of redirect.
- mem_addr  out  32  byte address to instruction memory (= pc register).
- mem_rd  out  1  read strobe, high exactly one cycle per fetch.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_rd.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr/pc_out are valid.
- pc_out  out  32  byte address of instr.
- halted  out  1  controller is in HALT.
- fault  out  1  sticky flag for a misaligned redirect.
- fetch_count  out  32  instructions consumed since the last start.

## Operation

- States are IDLE, ISSUE, WAIT, HOLD and HALT. Reset enters IDLE.
- Reset values:
  - pc=RESET_PC, so mem_addr=RESET_PC.
  - mem_rd=0, instr=0, instr_valid=0, pc_out=0.
  - halted=0, fault=0, fetch_count=0.
  - Internal latency counter lat_cnt=0.
- IDLE:
  - Ignores stall and redirect.
  - start -> ISSUE, with pc=RESET_PC and fetch_count=0.
- ISSUE:
  - If pc >= MEM_SIZE*4 -> HALT; no read is issued.
  - Otherwise mem_rd=1 for this cycle, lat_cnt<=MEM_LAT, -> WAIT.
- WAIT:
  - lat_cnt decrements each cycle.
  - At the edge where lat_cnt==1: instr<=mem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, -> HOLD.
- HOLD:
  - stall=1: stay; instr, pc_out and instr_valid are held unchanged.
  - stall=0: the instruction is consumed at this edge. fetch_count<=fetch_count+1, instr_valid<=0, -> ISSUE.
- Redirect handling in ISSUE/WAIT/HOLD; redirect has priority over everything else, including a stalled HOLD and a data capture in WAIT:
  - redirect_pc[1:0]!=0: fault<=1, instr_valid<=0, -> HALT; pc is unchanged.
  - Otherwise: pc<=redirect_pc, lat_cnt<=0, instr_valid<=0, -> ISSUE. Any in-flight read is discarded and its data never appears on instr.
  - A redirect in HOLD does not count as consumed; fetch_count is unchanged.
  - An aligned target >= MEM_SIZE*4 is not a fault. The controller reaches ISSUE, then HALT.
- HALT:
  - halted=1, mem_rd=0, instr_valid=0; redirect and stall are ignored.
  - start -> ISSUE with pc=RESET_PC, fetch_count=0, fault=0, halted=0.
- The PC increments by plain 32-bit +4. The end-of-memory check always precedes the issue, so the PC never wraps into valid space.
- start while in ISSUE/WAIT/HOLD is ignored.

## Timing

- mem_rd high in cycle T. mem_rdata is sampled at the rising edge ending cycle T+MEM_LAT. instr_valid is high from cycle T+MEM_LAT+1.
- Unstalled throughput is one instruction per MEM_LAT+2 cycles (ISSUE + MEM_LAT×WAIT + HOLD).
- The outputs mem_addr, mem_rd and halted are registered or derived from state only; there is no combinational path from an input to an output.
- redirect takes effect at the next edge. The new address is on mem_addr in the following ISSUE cycle, together with mem_rd=1.
- rst_n low at any time, including mid-WAIT, immediately forces all reset values. No partial read survives reset.

## Test plan

Benches use MEM_LAT=2, MEM_SIZE=4 and RESET_PC=0, with memory word k=32'hA000_0000+k.

- Reset, then a start pulse:
  - mem_rd is high with mem_addr=0 one cycle after start.
  - instr=A000_0000, instr_valid=1 and pc_out=0 three cycles after mem_rd.
  - Addresses then step 4, 8, 12 at a 4-cycle period.
- No stall through the end of memory:
  - After the fourth instruction is consumed, fetch_count=4.
  - The next ISSUE sees pc=16, enters HALT with halted=1, and mem_rd stays 0.
- stall held high for 5 cycles in HOLD:
  - instr and pc_out are stable and instr_valid stays 1.
  - fetch_count does not increment until the cycle stall drops.
- redirect to 12 during WAIT of the fetch at 4:
  - Word 1 is never presented.
  - The next valid instruction is A000_0003 with pc_out=12.
  - fetch_count is unchanged.
- redirect to 6 (misaligned):
  - fault=1 and halted=1 next cycle, with instr_valid=0.
  - A later start clears fault and refetches from 0.
- rst_n pulsed low mid-WAIT:
  - All outputs return to reset values asynchronously and the state is IDLE.
  - No instr_valid appears until a new start.
